// File: rtl/bridge_pkg.sv
// Shared encodings for the I2C-to-SPI bridge: FSM states, command byte fields, TX entry layout.
package bridge_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StLoad,
      StWait,
      StRelease
   } bridge_state_e;

   localparam int unsigned CMD_CS_LSB  = 0;
   localparam int unsigned CMD_CS_MSB  = 3;
   localparam int unsigned CMD_CAP_BIT = 7;

   // TX entry: {tag, byte}; tag marks the command byte of a transaction.
   localparam int unsigned ENTRY_W = 9;
   localparam int unsigned TAG_BIT = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty/count; push and pop may occur in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_wdata,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_rdata,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   // Head reads as zero when empty so the output is defined straight out of reset.
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

// File: rtl/i2c_spi_bridge_mux.sv
// I2C-to-SPI bridge: queues I2C bytes, routes each transaction to one chip-select and
// optionally captures MISO bytes for read-back on the I2C side.
module i2c_spi_bridge_mux
   import bridge_pkg::*;
#(
   parameter int unsigned DEPTH  = 8,
   parameter int unsigned NUM_CS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        i2c_rx_byte,
   input  logic              i2c_byte_valid,
   input  logic              i2c_is_addr,
   input  logic              i2c_bus_active,
   output logic [7:0]        i2c_rd_byte,
   output logic              i2c_rd_valid,
   input  logic              i2c_rd_ack,
   output logic [7:0]        spi_tx_byte,
   output logic              spi_tx_start,
   input  logic              spi_tx_done,
   input  logic [7:0]        spi_rx_byte,
   output logic [NUM_CS-1:0] spi_cs_n,
   output logic              tx_ovf,
   output logic              rx_ovf,
   output logic              cmd_err
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic               w_addr_stb;
   logic               w_data_stb;
   logic               w_tx_push;
   logic               w_tx_pop;
   logic               w_tx_full;
   logic               w_tx_empty;
   logic [ENTRY_W-1:0] w_tx_head;
   logic               w_rx_push;
   logic               w_rx_full;
   logic               w_rx_empty;
   logic [CW-1:0]      w_unused_tx_count;
   logic [CW-1:0]      w_unused_rx_count;

   logic               r_cmd_armed;
   bridge_state_e      r_state;
   logic [NUM_CS-1:0]  r_cs_n;
   logic               r_cap;
   logic               r_discard;
   logic [7:0]         r_tx_byte;
   logic               r_rx_push;
   logic [7:0]         r_rx_data;
   logic               r_tx_ovf;
   logic               r_rx_ovf;
   logic               r_cmd_err;

   bridge_state_e      w_state_nxt;
   logic [NUM_CS-1:0]  w_cs_n_nxt;
   logic               w_cap_nxt;
   logic               w_discard_nxt;
   logic [7:0]         w_tx_byte_nxt;
   logic               w_rx_push_nxt;
   logic [7:0]         w_rx_data_nxt;
   logic               w_cmd_err_set;
   logic               w_do_cmd;

   logic [3:0]         w_cmd_idx;
   logic               w_cmd_ok;
   logic               w_cs_any;
   logic [NUM_CS-1:0]  w_cs_dec;

   assign w_addr_stb = i2c_byte_valid & i2c_bus_active & i2c_is_addr;
   assign w_data_stb = i2c_byte_valid & i2c_bus_active & ~i2c_is_addr;
   assign w_tx_push  = w_data_stb & ~w_tx_full;
   assign w_rx_push  = r_rx_push & ~w_rx_full;

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_tx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_tx_push),
      .i_wdata ({r_cmd_armed, i2c_rx_byte}),
      .i_pop   (w_tx_pop),
      .o_rdata (w_tx_head),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_unused_tx_count)
   );

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_rx_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_rx_push),
      .i_wdata (r_rx_data),
      .i_pop   (i2c_rd_ack),
      .o_rdata (i2c_rd_byte),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_unused_rx_count)
   );

   assign w_cmd_idx = w_tx_head[CMD_CS_MSB:CMD_CS_LSB];
   assign w_cmd_ok  = (32'(w_cmd_idx) < NUM_CS);
   assign w_cs_any  = ~&r_cs_n;

   always_comb begin
      w_cs_dec = '1;
      for (int i = 0; i < NUM_CS; i++) begin
         if (w_cmd_idx == 4'(i)) begin
            w_cs_dec[i] = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cs_n_nxt    = r_cs_n;
      w_cap_nxt     = r_cap;
      w_discard_nxt = r_discard;
      w_tx_byte_nxt = r_tx_byte;
      w_rx_push_nxt = 1'b0;
      w_rx_data_nxt = r_rx_data;
      w_cmd_err_set = 1'b0;
      w_tx_pop      = 1'b0;
      w_do_cmd      = 1'b0;
      case (r_state)
         StIdle: begin
            if (!w_tx_empty) begin
               if (w_tx_head[TAG_BIT]) begin
                  // Repeated start: release first, the command stays queued for RELEASE.
                  if (w_cs_any) begin
                     w_cs_n_nxt  = '1;
                     w_state_nxt = StRelease;
                  end else begin
                     w_do_cmd = 1'b1;
                  end
               end else begin
                  w_tx_pop = 1'b1;
                  if (!r_discard && w_cs_any) begin
                     w_tx_byte_nxt = w_tx_head[7:0];
                     w_state_nxt   = StLoad;
                  end
               end
            end else if (w_cs_any && !i2c_bus_active) begin
               w_cs_n_nxt  = '1;
               w_state_nxt = StRelease;
            end
         end
         StSetup: w_state_nxt = StIdle;
         StLoad:  w_state_nxt = StWait;
         StWait: begin
            if (spi_tx_done) begin
               w_rx_push_nxt = r_cap;
               w_rx_data_nxt = spi_rx_byte;
               w_state_nxt   = StIdle;
            end
         end
         StRelease: begin
            w_cap_nxt     = 1'b0;
            w_discard_nxt = 1'b0;
            w_state_nxt   = StIdle;
            // Taking a pending command here keeps the CS-high gap to a single cycle.
            w_do_cmd      = !w_tx_empty && w_tx_head[TAG_BIT];
         end
         default: w_state_nxt = StIdle;
      endcase

      if (w_do_cmd) begin
         w_tx_pop = 1'b1;
         if (w_cmd_ok) begin
            w_cs_n_nxt    = w_cs_dec;
            w_cap_nxt     = w_tx_head[CMD_CAP_BIT];
            w_discard_nxt = 1'b0;
            w_state_nxt   = StSetup;
         end else begin
            w_cmd_err_set = 1'b1;
            w_discard_nxt = 1'b1;
            w_state_nxt   = StIdle;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_cs_n    <= '1;
         r_cap     <= 1'b0;
         r_discard <= 1'b0;
         r_tx_byte <= '0;
         r_rx_push <= 1'b0;
         r_rx_data <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_cs_n    <= w_cs_n_nxt;
         r_cap     <= w_cap_nxt;
         r_discard <= w_discard_nxt;
         r_tx_byte <= w_tx_byte_nxt;
         r_rx_push <= w_rx_push_nxt;
         r_rx_data <= w_rx_data_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd_armed <= 1'b0;
         r_tx_ovf    <= 1'b0;
         r_rx_ovf    <= 1'b0;
         r_cmd_err   <= 1'b0;
      end else begin
         if (w_addr_stb) begin
            r_cmd_armed <= 1'b1;
            r_tx_ovf    <= 1'b0;
            r_rx_ovf    <= 1'b0;
            r_cmd_err   <= 1'b0;
         end else if (w_data_stb) begin
            r_cmd_armed <= 1'b0;
         end
         if (w_data_stb && w_tx_full) begin
            r_tx_ovf <= 1'b1;
         end
         if (r_rx_push && w_rx_full) begin
            r_rx_ovf <= 1'b1;
         end
         if (w_cmd_err_set) begin
            r_cmd_err <= 1'b1;
         end
      end
   end

   assign spi_tx_start = (r_state == StLoad);
   assign spi_tx_byte  = r_tx_byte;
   assign spi_cs_n     = r_cs_n;
   assign i2c_rd_valid = ~w_rx_empty;
   assign tx_ovf       = r_tx_ovf;
   assign rx_ovf       = r_rx_ovf;
   assign cmd_err      = r_cmd_err;

endmodule

// File: tb/tb_i2c_spi_bridge_mux.sv
`timescale 1ns/1ps
// Directed bench for i2c_spi_bridge_mux: SPI engine responder plus queues of expected
// SPI bytes (with chip-select) and expected RX read-back bytes.
module tb_i2c_spi_bridge_mux;
   localparam int unsigned DEPTH  = 8;
   localparam int unsigned NUM_CS = 4;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        i2c_rx_byte;
   logic              i2c_byte_valid;
   logic              i2c_is_addr;
   logic              i2c_bus_active;
   logic [7:0]        i2c_rd_byte;
   logic              i2c_rd_valid;
   logic              i2c_rd_ack;
   logic [7:0]        spi_tx_byte;
   logic              spi_tx_start;
   logic              spi_tx_done;
   logic [7:0]        spi_rx_byte;
   logic [NUM_CS-1:0] spi_cs_n;
   logic              tx_ovf;
   logic              rx_ovf;
   logic              cmd_err;

   int checks = 0;
   int errors = 0;
   int n_starts = 0;
   int cyc = 0;
   int done_cyc = 0;
   int last_gap = 0;
   int eng_delay = 3;
   bit eng_stall = 1'b0;
   bit rs_mon = 1'b0;
   int hi_run = 0;
   int gaps = 0;
   int last_hi = 0;
   bit seen_low = 1'b0;
   int base;

   logic [11:0] exp_spi[$];
   logic [7:0]  miso_q[$];
   logic [7:0]  exp_rd[$];

   i2c_spi_bridge_mux #(
      .DEPTH  (DEPTH),
      .NUM_CS (NUM_CS)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i2c_rx_byte    (i2c_rx_byte),
      .i2c_byte_valid (i2c_byte_valid),
      .i2c_is_addr    (i2c_is_addr),
      .i2c_bus_active (i2c_bus_active),
      .i2c_rd_byte    (i2c_rd_byte),
      .i2c_rd_valid   (i2c_rd_valid),
      .i2c_rd_ack     (i2c_rd_ack),
      .spi_tx_byte    (spi_tx_byte),
      .spi_tx_start   (spi_tx_start),
      .spi_tx_done    (spi_tx_done),
      .spi_rx_byte    (spi_rx_byte),
      .spi_cs_n       (spi_cs_n),
      .tx_ovf         (tx_ovf),
      .rx_ovf         (rx_ovf),
      .cmd_err        (cmd_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // SPI engine: checks each start against the scoreboard, then answers with a done strobe.
   always begin
      @(negedge clk);
      if (rst_n && spi_tx_start) begin
         logic [11:0] e;
         n_starts++;
         last_gap = cyc - done_cyc;
         chk("start_expected", 32'(exp_spi.size() != 0), 1);
         if (exp_spi.size() != 0) begin
            e = exp_spi.pop_front();
            chk("spi_tx_byte", 32'(spi_tx_byte), 32'(e[7:0]));
            chk("spi_cs_at_start", 32'(spi_cs_n), 32'(e[11:8]));
         end
         while (eng_stall) @(negedge clk);
         repeat (eng_delay) @(negedge clk);
         @(posedge clk);
         #1;
         spi_rx_byte = (miso_q.size() != 0) ? miso_q.pop_front() : 8'hEE;
         spi_tx_done = 1'b1;
         done_cyc    = cyc;
         @(posedge clk);
         #1;
         spi_tx_done = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cs_at_most_one_low", 32'($countones(~spi_cs_n) <= 1), 1);
      end
      if (rs_mon) begin
         if (spi_cs_n == '1) begin
            hi_run++;
         end else begin
            if (seen_low && hi_run != 0) begin
               gaps++;
               last_hi = hi_run;
            end
            hi_run   = 0;
            seen_low = 1'b1;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic strobe(input logic [7:0] b, input logic addr);
      @(posedge clk);
      #1;
      i2c_rx_byte    = b;
      i2c_is_addr    = addr;
      i2c_byte_valid = 1'b1;
      @(posedge clk);
      #1;
      i2c_byte_valid = 1'b0;
      i2c_is_addr    = 1'b0;
   endtask

   task automatic send(input logic [7:0] b, input logic addr);
      strobe(b, addr);
      repeat (4) @(posedge clk);
   endtask

   task automatic wait_starts(input int target, input string tag);
      for (int i = 0; i < 500 && n_starts < target; i++) @(negedge clk);
      chk(tag, n_starts, target);
   endtask

   task automatic wait_cs_idle(input string tag);
      for (int i = 0; i < 300 && spi_cs_n != '1; i++) @(negedge clk);
      chk(tag, 32'(spi_cs_n), 32'(4'b1111));
   endtask

   task automatic read_rd(input string tag);
      logic [7:0] e;
      for (int i = 0; i < 100 && !i2c_rd_valid; i++) @(negedge clk);
      chk({tag, "_valid"}, 32'(i2c_rd_valid), 1);
      e = (exp_rd.size() != 0) ? exp_rd.pop_front() : 8'h00;
      chk(tag, 32'(i2c_rd_byte), 32'(e));
      @(posedge clk);
      #1;
      i2c_rd_ack = 1'b1;
      @(posedge clk);
      #1;
      i2c_rd_ack = 1'b0;
   endtask

   initial begin
      rst_n          = 1'b0;
      i2c_rx_byte    = '0;
      i2c_byte_valid = 1'b0;
      i2c_is_addr    = 1'b0;
      i2c_bus_active = 1'b0;
      i2c_rd_ack     = 1'b0;
      spi_tx_done    = 1'b0;
      spi_rx_byte    = '0;

      // Reset values
      @(negedge clk);
      chk("rst_cs_n", 32'(spi_cs_n), 32'(4'b1111));
      chk("rst_tx_start", 32'(spi_tx_start), 0);
      chk("rst_tx_byte", 32'(spi_tx_byte), 0);
      chk("rst_rd_valid", 32'(i2c_rd_valid), 0);
      chk("rst_rd_byte", 32'(i2c_rd_byte), 0);
      chk("rst_flags", 32'({tx_ovf, rx_ovf, cmd_err}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Test 1: cmd 0x01, data A5 3C, CS1 held, released after bus idle
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      strobe(8'h01, 1'b0);
      @(negedge clk);
      chk("t1_cs_n_cycle1", 32'(spi_cs_n), 32'(4'b1111));
      @(negedge clk);
      chk("t1_cs_n_cycle2", 32'(spi_cs_n), 32'(4'b1101));
      exp_spi.push_back({4'b1101, 8'hA5});
      strobe(8'hA5, 1'b0);
      @(negedge clk);
      chk("t1_start_cycle1", 32'(spi_tx_start), 0);
      @(negedge clk);
      chk("t1_start_cycle2", 32'(spi_tx_start), 1);
      exp_spi.push_back({4'b1101, 8'h3C});
      send(8'h3C, 1'b0);
      i2c_bus_active = 1'b0;
      wait_cs_idle("t1_release");
      chk("t1_starts", n_starts, 2);
      chk("t1_no_capture", 32'(i2c_rd_valid), 0);

      // Test 2: capture on CS2, read back 5A then C3
      base = n_starts;
      exp_spi.push_back({4'b1011, 8'h11});
      exp_spi.push_back({4'b1011, 8'h22});
      miso_q.push_back(8'h5A);
      miso_q.push_back(8'hC3);
      exp_rd.push_back(8'h5A);
      exp_rd.push_back(8'hC3);
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      send(8'h82, 1'b0);
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      i2c_bus_active = 1'b0;
      wait_cs_idle("t2_release");
      chk("t2_starts", n_starts, base + 2);
      read_rd("t2_rd0");
      read_rd("t2_rd1");
      @(negedge clk);
      chk("t2_rd_valid_drop", 32'(i2c_rd_valid), 0);

      // Test 3: TX overflow with engine stalled
      base      = n_starts;
      eng_delay = 0;
      eng_stall = 1'b1;
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      send(8'h01, 1'b0);
      for (int i = 0; i < DEPTH + 3; i++) begin
         if (i <= DEPTH) exp_spi.push_back({4'b1101, 8'(8'h10 + i)});
         send(8'(8'h10 + i), 1'b0);
      end
      chk("t3_tx_ovf", 32'(tx_ovf), 1);
      chk("t3_starts_stalled", n_starts, base + 1);
      eng_stall = 1'b0;
      wait_starts(base + DEPTH + 1, "t3_accepted");
      repeat (20) @(negedge clk);
      chk("t3_accepted_exact", n_starts, base + DEPTH + 1);
      chk("t3_b2b_gap", last_gap, 2);
      i2c_bus_active = 1'b0;
      wait_cs_idle("t3_release");
      chk("t3_tx_ovf_sticky", 32'(tx_ovf), 1);
      eng_delay = 3;

      // Test 4: repeated start CS0 -> CS3 with a single-cycle CS gap
      base     = n_starts;
      hi_run   = 0;
      gaps     = 0;
      last_hi  = 0;
      seen_low = 1'b0;
      rs_mon   = 1'b1;
      exp_spi.push_back({4'b1110, 8'hB1});
      exp_spi.push_back({4'b1110, 8'hB2});
      exp_spi.push_back({4'b0111, 8'hB3});
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      chk("t4_tx_ovf_cleared", 32'(tx_ovf), 0);
      send(8'h00, 1'b0);
      send(8'hB1, 1'b0);
      send(8'hB2, 1'b0);
      send(8'hA0, 1'b1);
      send(8'h03, 1'b0);
      send(8'hB3, 1'b0);
      i2c_bus_active = 1'b0;
      wait_starts(base + 3, "t4_starts");
      wait_cs_idle("t4_release");
      rs_mon = 1'b0;
      chk("t4_gap_count", gaps, 1);
      chk("t4_gap_len", last_hi, 1);

      // Test 5: invalid chip-select index
      base = n_starts;
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      send(8'h0F, 1'b0);
      chk("t5_cmd_err", 32'(cmd_err), 1);
      chk("t5_cs_after_cmd", 32'(spi_cs_n), 32'(4'b1111));
      send(8'h77, 1'b0);
      repeat (10) @(negedge clk);
      chk("t5_cs_after_data", 32'(spi_cs_n), 32'(4'b1111));
      chk("t5_no_start", n_starts, base);
      i2c_bus_active = 1'b0;

      // Test 6: reset while waiting on the engine with CS1 low
      base      = n_starts;
      eng_stall = 1'b1;
      i2c_bus_active = 1'b1;
      send(8'hA0, 1'b1);
      chk("t6_cmd_err_cleared", 32'(cmd_err), 0);
      send(8'h01, 1'b0);
      exp_spi.push_back({4'b1101, 8'h99});
      send(8'h99, 1'b0);
      send(8'h98, 1'b0);
      wait_starts(base + 1, "t6_started");
      @(negedge clk);
      chk("t6_cs1_low", 32'(spi_cs_n), 32'(4'b1101));
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_cs_async_release", 32'(spi_cs_n), 32'(4'b1111));
      chk("t6_start_in_reset", 32'(spi_tx_start), 0);
      exp_spi.delete();
      miso_q.delete();
      i2c_bus_active = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      eng_stall = 1'b0;
      repeat (20) @(negedge clk);
      chk("t6_tx_flushed", n_starts, base + 1);
      chk("t6_rd_valid", 32'(i2c_rd_valid), 0);
      chk("t6_rd_byte", 32'(i2c_rd_byte), 0);
      chk("t6_cs_idle", 32'(spi_cs_n), 32'(4'b1111));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
